// File: rtl/mac_out_packer.sv
// Output packer for the sequential MAC accelerator: captures whole result vectors
// into a small FIFO and streams them out as busWidth beats over a valid/ready bus.
module mac_out_packer #(
   parameter int outputElements = 32,
   parameter int outputBits     = 4,
   parameter int busWidth       = 32,
   parameter int depth          = 2,
   localparam int beatsPerVec   = outputElements*outputBits/busWidth,
   localparam int cntBits       = $clog2(depth+1)
) (
   input  logic                                       clk,
   input  logic                                       nrst,
   input  logic [outputElements-1:0][outputBits-1:0]  mac_data_i,
   input  logic                                       mac_valid_i,
   output logic                                       stall_o,
   output logic [busWidth-1:0]                        out_data_o,
   output logic                                       out_valid_o,
   input  logic                                       out_ready_i,
   output logic                                       out_last_o,
   output logic [cntBits-1:0]                         occupancy_o,
   output logic                                       overflow_o,
   input  logic                                       clear_i
);

   localparam int vecBits  = outputElements*outputBits;
   localparam int ptrBits  = (depth > 1) ? $clog2(depth) : 1;
   localparam int beatBits = (beatsPerVec > 1) ? $clog2(beatsPerVec) : 1;

   logic [vecBits-1:0]  mem [depth];
   logic [ptrBits-1:0]  wr_ptr;
   logic [ptrBits-1:0]  rd_ptr;
   logic [cntBits-1:0]  occ;
   logic [beatBits-1:0] beat_cnt;
   logic                ovf;
   logic [vecBits-1:0]  head;
   logic                last_beat;
   logic                xfer;
   logic                pop;
   logic                push;
   logic                drop;

   // depth need not be a power of two, so wrap by compare-and-reset
   function automatic logic [ptrBits-1:0] ptr_next(input logic [ptrBits-1:0] p);
      return (p == ptrBits'(depth-1)) ? '0 : p + 1'b1;
   endfunction

   // Handshake: a beat moves when out_valid_o && out_ready_i; while valid is high
   // and ready low, data/valid/last hold because head and beat_cnt do not change.
   assign head        = mem[rd_ptr];
   assign out_valid_o = (occ != '0);
   assign last_beat   = (beat_cnt == beatBits'(beatsPerVec-1));
   assign xfer        = out_valid_o && out_ready_i;
   assign pop         = xfer && last_beat;
   assign push        = mac_valid_i && ((occ != cntBits'(depth)) || pop);
   assign drop        = mac_valid_i && !push;
   assign out_last_o  = out_valid_o && last_beat;
   assign out_data_o  = out_valid_o ? head[beat_cnt*busWidth +: busWidth] : '0;
   assign occupancy_o = occ;
   assign overflow_o  = ovf;

   // One slot stays reserved for a result already in the accelerator pipeline.
   assign stall_o     = (occ >= cntBits'(depth-1));

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         beat_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         if (push && !pop)      occ <= occ + 1'b1;
         else if (pop && !push) occ <= occ - 1'b1;
         if (xfer) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
         if (drop)         ovf <= 1'b1;
         else if (clear_i) ovf <= 1'b0;
      end
   end

   // Storage needs no reset: out_data_o is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= mac_data_i;
   end

endmodule

// File: tb/tb_mac_out_packer.sv
// Bench for mac_out_packer: directed scenarios plus random traffic, checked by a
// beat-queue scoreboard and a vector-count model of the FIFO.
module tb_mac_out_packer;

   localparam int E   = 32;
   localparam int B   = 4;
   localparam int BW  = 32;
   localparam int D   = 2;
   localparam int BPV = E*B/BW;
   localparam int VW  = E*B;
   localparam int CB  = $clog2(D+1);

   logic                  clk;
   logic                  nrst;
   logic [E-1:0][B-1:0]   mac_data;
   logic                  mac_valid;
   logic                  stall;
   logic [BW-1:0]         out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;
   logic [CB-1:0]         occupancy;
   logic                  overflow;
   logic                  clear;

   int n_checks = 0;
   int n_fail   = 0;

   // expected beats: {last, data}
   logic [BW:0] exp_q[$];
   int          m_occ = 0;
   logic        m_ovf = 1'b0;

   mac_out_packer #(
      .outputElements(E), .outputBits(B), .busWidth(BW), .depth(D)
   ) dut (
      .clk(clk), .nrst(nrst), .mac_data_i(mac_data), .mac_valid_i(mac_valid),
      .stall_o(stall), .out_data_o(out_data), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_last_o(out_last), .occupancy_o(occupancy),
      .overflow_o(overflow), .clear_i(clear)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // monitor / scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      logic        pop_m;
      logic        drop_m;
      logic [VW-1:0] v;
      if (!nrst) begin
         exp_q.delete();
         m_occ = 0;
         m_ovf = 1'b0;
         chk("rst_valid", 64'(out_valid), 64'd0);
         chk("rst_occ", 64'(occupancy), 64'd0);
      end else begin
         pop_m  = 1'b0;
         drop_m = 1'b0;
         chk("occupancy", 64'(occupancy), 64'(m_occ));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         chk("stall", 64'(stall), 64'(m_occ >= D-1));
         chk("valid", 64'(out_valid), 64'(m_occ != 0));
         if (m_occ == 0) chk("empty_data", 64'(out_data), 64'd0);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'(out_data), 64'hdead);
            end else begin
               chk("beat_data", 64'(out_data), 64'(exp_q[0][BW-1:0]));
               chk("beat_last", 64'(out_last), 64'(exp_q[0][BW]));
               if (out_ready) begin
                  pop_m = exp_q[0][BW];
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            chk("idle_last", 64'(out_last), 64'd0);
         end
         if (mac_valid) begin
            if (m_occ < D || pop_m) begin
               v = mac_data;
               for (int k = 0; k < BPV; k++)
                  exp_q.push_back({(k == BPV-1), v[k*BW +: BW]});
               m_occ = m_occ + 1;
            end else begin
               drop_m = 1'b1;
            end
         end
         if (pop_m) m_occ = m_occ - 1;
         if (drop_m)     m_ovf = 1'b1;
         else if (clear) m_ovf = 1'b0;
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_vec(input logic [VW-1:0] v, input logic clr);
      mac_data  = v;
      mac_valid = 1'b1;
      clear     = clr;
      cyc();
      mac_valid = 1'b0;
      clear     = 1'b0;
   endtask

   function automatic logic [VW-1:0] lane_pattern();
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < E; i++) v[i*B +: B] = 4'(i % 16);
      return v;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < VW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic drain(input int n);
      out_ready = 1'b1;
      repeat (n) cyc();
   endtask

   initial begin
      logic [BW-1:0] held;
      logic          found;
      nrst      = 1'b0;
      mac_data  = '0;
      mac_valid = 1'b0;
      out_ready = 1'b0;
      clear     = 1'b0;
      repeat (3) cyc();
      chk("reset_data", 64'(out_data), 64'd0);
      chk("reset_stall", 64'(stall), 64'd0);
      chk("reset_ovf", 64'(overflow), 64'd0);
      chk("reset_last", 64'(out_last), 64'd0);
      nrst = 1'b1;
      cyc();

      // single vector, lane i = i mod 16
      out_ready = 1'b1;
      send_vec(lane_pattern(), 1'b0);
      chk("t1_beat0", 64'(out_data), 64'h76543210);
      chk("t1_last0", 64'(out_last), 64'd0);
      cyc();
      chk("t1_beat1", 64'(out_data), 64'hFEDCBA98);
      cyc();
      chk("t1_beat2", 64'(out_data), 64'h76543210);
      chk("t1_last2", 64'(out_last), 64'd0);
      cyc();
      chk("t1_beat3", 64'(out_data), 64'hFEDCBA98);
      chk("t1_last3", 64'(out_last), 64'd1);
      cyc();
      chk("t1_occ_end", 64'(occupancy), 64'd0);

      // backpressure with ready pattern 1,0,0,1
      out_ready = 1'b0;
      send_vec(rand_vec(), 1'b0);
      send_vec(rand_vec(), 1'b0);
      for (int i = 0; i < 24; i++) begin
         out_ready = (i % 4 == 0) || (i % 4 == 3);
         held = out_data;
         cyc();
         if (!out_ready && out_valid) chk("t2_hold", 64'(out_data), 64'(held));
      end
      drain(10);

      // fill, drop, overflow
      out_ready = 1'b0;
      send_vec(rand_vec(), 1'b0);
      chk("t3_stall", 64'(stall), 64'd1);
      chk("t3_occ1", 64'(occupancy), 64'd1);
      send_vec(rand_vec(), 1'b0);
      chk("t3_occ2", 64'(occupancy), 64'd2);
      send_vec(rand_vec(), 1'b0);
      chk("t3_ovf", 64'(overflow), 64'd1);
      chk("t3_occ_full", 64'(occupancy), 64'd2);
      drain(10);
      chk("t3_occ_end", 64'(occupancy), 64'd0);
      chk("t3_c_absent", 64'(exp_q.size()), 64'd0);

      // clear without drop
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk("t5_clear", 64'(overflow), 64'd0);

      // push while full on the final beat of the head
      out_ready = 1'b0;
      send_vec(rand_vec(), 1'b0);
      send_vec(rand_vec(), 1'b0);
      out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (out_last) found = 1'b1;
         else cyc();
      end
      chk("t4_last_seen", 64'(found), 64'd1);
      send_vec(rand_vec(), 1'b0);
      chk("t4_occ", 64'(occupancy), 64'd2);
      chk("t4_ovf", 64'(overflow), 64'd0);
      drain(14);

      // clear coinciding with a drop: set wins
      out_ready = 1'b0;
      send_vec(rand_vec(), 1'b0);
      send_vec(rand_vec(), 1'b0);
      send_vec(rand_vec(), 1'b1);
      chk("t5_set_wins", 64'(overflow), 64'd1);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk("t5_clear2", 64'(overflow), 64'd0);
      drain(10);

      // asynchronous reset mid-vector
      out_ready = 1'b1;
      send_vec(rand_vec(), 1'b0);
      cyc();
      cyc();
      #2 nrst = 1'b0;
      #1;
      chk("t6_valid", 64'(out_valid), 64'd0);
      chk("t6_data", 64'(out_data), 64'd0);
      chk("t6_occ", 64'(occupancy), 64'd0);
      chk("t6_last", 64'(out_last), 64'd0);
      chk("t6_stall", 64'(stall), 64'd0);
      cyc();
      nrst = 1'b1;
      cyc();
      send_vec(lane_pattern(), 1'b0);
      chk("t6_beat0", 64'(out_data), 64'h76543210);
      drain(6);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         mac_data  = rand_vec();
         mac_valid = ($urandom_range(0, 3) == 0);
         out_ready = $urandom_range(0, 1);
         clear     = ($urandom_range(0, 15) == 0);
         cyc();
      end
      mac_valid = 1'b0;
      clear     = 1'b0;
      drain(20);
      chk("final_drain", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
